// File: rtl/uart_char_rx_pkg.sv
// Constants shared by the UART receive path.
package uart_char_rx_pkg;

   localparam logic        UART_IDLE_LEVEL = 1'b1;
   localparam int unsigned UART_DATA_BITS  = 8;

endpackage

// File: rtl/byte_fifo.sv
// Synchronous first-word-fall-through FIFO; head word is visible whenever not empty.
module byte_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         pop_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full     = (count == (AW+1)'(DEPTH));
   assign empty    = (count == '0);
   // A full FIFO still accepts a push when a pop frees the head slot in the same cycle.
   assign do_pop   = pop && !empty;
   assign do_push  = push && (!full || do_pop);
   assign pop_data = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/uart_char_rx.sv
// 8N1 UART receiver: synchroniser, bit timer and framing FSM feeding a byte FIFO.
module uart_char_rx
   import uart_char_rx_pkg::*;
#(
   parameter int CLKS_PER_BIT = 868,
   parameter int FIFO_DEPTH   = 16
) (
   input  logic                          clk_in,
   input  logic                          rst_in,
   input  logic                          rx_in,
   output logic [7:0]                    char_out,
   output logic                          char_out_valid,
   input  logic                          char_out_ready,
   output logic                          framing_error,
   output logic                          overflow,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   localparam int TW = $clog2(CLKS_PER_BIT);
   localparam int IW = $clog2(UART_DATA_BITS);
   localparam logic [TW-1:0] HALF_LAST = TW'(CLKS_PER_BIT/2 - 1);
   localparam logic [TW-1:0] FULL_LAST = TW'(CLKS_PER_BIT - 1);
   localparam logic [IW-1:0] IDX_LAST  = IW'(UART_DATA_BITS - 1);

   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP,
      RX_BREAK
   } rx_state_t;

   rx_state_t                 state;
   logic                      rx_meta;
   logic                      rx_s;
   logic [TW-1:0]             timer;
   logic [IW-1:0]             idx;
   logic [UART_DATA_BITS-1:0] shreg;
   logic                      push;
   logic                      pop;
   logic                      full;
   logic                      empty;

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         rx_meta <= UART_IDLE_LEVEL;
         rx_s    <= UART_IDLE_LEVEL;
      end else begin
         rx_meta <= rx_in;
         rx_s    <= rx_meta;
      end
   end

   // Byte is written on the stop-sample cycle itself, so the push is decoded combinationally.
   assign push           = (state == RX_STOP) && (timer == FULL_LAST) && (rx_s == UART_IDLE_LEVEL);
   assign pop            = char_out_valid && char_out_ready;
   assign char_out_valid = !empty;

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state         <= RX_IDLE;
         timer         <= '0;
         idx           <= '0;
         shreg         <= '0;
         framing_error <= 1'b0;
         overflow      <= 1'b0;
      end else begin
         framing_error <= 1'b0;
         overflow      <= push && full && !pop;
         case (state)
            RX_IDLE: begin
               timer <= '0;
               if (rx_s != UART_IDLE_LEVEL) begin
                  state <= RX_START;
               end
            end
            RX_START: begin
               if (timer == HALF_LAST) begin
                  timer <= '0;
                  idx   <= '0;
                  state <= (rx_s == UART_IDLE_LEVEL) ? RX_IDLE : RX_DATA;
               end else begin
                  timer <= timer + TW'(1);
               end
            end
            RX_DATA: begin
               if (timer == FULL_LAST) begin
                  timer <= '0;
                  shreg <= {rx_s, shreg[UART_DATA_BITS-1:1]};
                  if (idx == IDX_LAST) begin
                     state <= RX_STOP;
                  end else begin
                     idx <= idx + IW'(1);
                  end
               end else begin
                  timer <= timer + TW'(1);
               end
            end
            RX_STOP: begin
               if (timer == FULL_LAST) begin
                  timer <= '0;
                  if (rx_s == UART_IDLE_LEVEL) begin
                     state <= RX_IDLE;
                  end else begin
                     framing_error <= 1'b1;
                     state         <= RX_BREAK;
                  end
               end else begin
                  timer <= timer + TW'(1);
               end
            end
            RX_BREAK: begin
               timer <= '0;
               if (rx_s == UART_IDLE_LEVEL) begin
                  state <= RX_IDLE;
               end
            end
            default: begin
               state <= RX_IDLE;
               timer <= '0;
            end
         endcase
      end
   end

   byte_fifo #(
      .WIDTH (UART_DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk_in),
      .rst       (rst_in),
      .push      (push),
      .push_data (shreg),
      .pop       (pop),
      .pop_data  (char_out),
      .full      (full),
      .empty     (empty),
      .count     (fifo_count)
   );

endmodule

// File: tb/tb_uart_char_rx.sv
// Directed bench for uart_char_rx with a byte scoreboard checked on every handshake.
module tb_uart_char_rx;

   localparam int CPB   = 4;
   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       rst_in;
   logic       rx_in;
   logic [7:0] char_out;
   logic       char_out_valid;
   logic       char_out_ready;
   logic       framing_error;
   logic       overflow;
   logic [2:0] fifo_count;

   int checks   = 0;
   int failures = 0;
   int beats    = 0;
   int fe_cnt   = 0;
   int ovf_cnt  = 0;
   logic [7:0] q[$];

   uart_char_rx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
      .clk_in         (clk),
      .rst_in         (rst_in),
      .rx_in          (rx_in),
      .char_out       (char_out),
      .char_out_valid (char_out_valid),
      .char_out_ready (char_out_ready),
      .framing_error  (framing_error),
      .overflow       (overflow),
      .fifo_count     (fifo_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drive_bit(input logic b);
      rx_in = b;
      tick(CPB);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop_bit);
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(d[i]);
      drive_bit(stop_bit);
   endtask

   task automatic drain();
      int n;
      n = 0;
      char_out_ready = 1'b1;
      while (q.size() != 0 && n < 300) begin
         tick(1);
         n++;
      end
      tick(2);
      char_out_ready = 1'b0;
      check("drain_done", q.size(), 0);
   endtask

   // Scoreboard: every accepted beat must match the oldest expected byte.
   always @(negedge clk) begin
      if (!rst_in) begin
         if (char_out_valid === 1'b1 && char_out_ready === 1'b1) begin
            beats++;
            if (q.size() == 0) begin
               check("unexpected_beat", {24'h0, char_out}, 32'hFFFF_FFFF);
            end else begin
               check("char_out", {24'h0, char_out}, {24'h0, q.pop_front()});
            end
         end
         if (framing_error === 1'b1) fe_cnt++;
         if (overflow === 1'b1) ovf_cnt++;
         if (framing_error === 1'b1 && overflow === 1'b1) begin
            check("fe_ovf_exclusive", 1, 0);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int b0, f0, o0;
      rst_in = 1'b1;
      rx_in = 1'b1;
      char_out_ready = 1'b0;
      tick(4);
      check("rst_char_out", char_out, 8'h00);
      check("rst_valid", char_out_valid, 1'b0);
      check("rst_fe", framing_error, 1'b0);
      check("rst_ovf", overflow, 1'b0);
      check("rst_count", fifo_count, 3'd0);
      rst_in = 1'b0;
      tick(4);

      // 1: single byte with latency check
      b0 = beats; f0 = fe_cnt; o0 = ovf_cnt;
      char_out_ready = 1'b1;
      q.push_back(8'h61);
      send_frame(8'h61, 1'b1);
      check("t1_pre_valid", char_out_valid, 1'b0);
      tick(1);
      check("t1_valid", char_out_valid, 1'b1);
      check("t1_head", char_out, 8'h61);
      drain();
      check("t1_beats", beats - b0, 1);
      check("t1_fe", fe_cnt - f0, 0);
      check("t1_ovf", ovf_cnt - o0, 0);

      // 2: back-to-back "go\n" held, then drained in order
      b0 = beats;
      char_out_ready = 1'b0;
      q.push_back(8'h67); send_frame(8'h67, 1'b1);
      q.push_back(8'h6F); send_frame(8'h6F, 1'b1);
      q.push_back(8'h0A); send_frame(8'h0A, 1'b1);
      tick(3);
      check("t2_count", fifo_count, 3'd3);
      check("t2_head_hold", char_out, 8'h67);
      drain();
      check("t2_beats", beats - b0, 3);
      check("t2_count_empty", fifo_count, 3'd0);

      // 3: short glitch is ignored, receiver still works afterwards
      f0 = fe_cnt;
      rx_in = 1'b0;
      tick(1);
      rx_in = 1'b1;
      tick(12);
      check("t3_valid", char_out_valid, 1'b0);
      check("t3_count", fifo_count, 3'd0);
      check("t3_fe", fe_cnt - f0, 0);
      q.push_back(8'h52);
      send_frame(8'h52, 1'b1);
      drain();

      // 4: framing error with line held low, then recovery
      f0 = fe_cnt; b0 = beats;
      send_frame(8'h55, 1'b0);
      tick(3 * CPB);
      rx_in = 1'b1;
      tick(8);
      check("t4_fe", fe_cnt - f0, 1);
      check("t4_count", fifo_count, 3'd0);
      check("t4_valid", char_out_valid, 1'b0);
      q.push_back(8'h31);
      send_frame(8'h31, 1'b1);
      drain();
      check("t4_beats", beats - b0, 1);

      // 5: overflow on the fifth byte, then push+pop while full
      o0 = ovf_cnt;
      for (int i = 0; i < 5; i++) begin
         if (i < DEPTH) q.push_back(8'h30 + 8'(i));
         send_frame(8'h30 + 8'(i), 1'b1);
      end
      tick(3);
      check("t5_ovf", ovf_cnt - o0, 1);
      check("t5_count_full", fifo_count, 3'd4);
      q.push_back(8'h35);
      send_frame(8'h35, 1'b1);
      char_out_ready = 1'b1;
      tick(1);
      char_out_ready = 1'b0;
      check("t5_count_pushpop", fifo_count, 3'd4);
      tick(3);
      check("t5_ovf_after", ovf_cnt - o0, 1);
      check("t5_head_next", char_out, 8'h31);
      drain();

      // 6: reset during DATA clears FIFO and aborts frame
      b0 = beats;
      q.push_back(8'h11);
      send_frame(8'h11, 1'b1);
      tick(3);
      check("t6_count_pre", fifo_count, 3'd1);
      drive_bit(1'b0);
      drive_bit(1'b0);
      drive_bit(1'b1);
      drive_bit(1'b0);
      rst_in = 1'b1;
      rx_in = 1'b1;
      q.delete();
      tick(2);
      check("t6_valid", char_out_valid, 1'b0);
      check("t6_count", fifo_count, 3'd0);
      check("t6_char_out", char_out, 8'h00);
      rst_in = 1'b0;
      tick(4);
      q.push_back(8'h41);
      send_frame(8'h41, 1'b1);
      drain();
      check("t6_beats", beats - b0, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
